// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle RV32I control FSM. It accepts one instruction per handshake,
//   decodes it, and steps through FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//   In each state it drives the ALU opcode and the register-file, data-memory
//   and PC enables.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   instr[31:0]       : instruction word, captured into IR on the FETCH handshake
//   instr_valid       : instruction source has a word
//   instr_ready       : FSM is in FETCH and will accept
//   Zero              : ALU result == 0, used only in the EXEC cycle of a branch
//   mem_ready         : data memory completes its access this cycle (MEM only)
//   ALUCtrl[3:0]      : ALU opcode, held constant from EXEC through MEM/WB
//   alu_a_pc          : ALU A operand = PC (1) / rs1 (0)
//   alu_b_imm         : ALU B operand = immediate (1) / rs2 (0)
//   mem_re, mem_we    : load / store request, held until mem_ready
//   reg_we            : register-file write (WB)
//   wb_sel[1:0]       : 00 ALU result, 01 load data, 10 PC+4
//   pc_we             : PC update, one cycle per retired instruction
//   pc_src[1:0]       : 00 PC+4, 01 PC+imm, 10 ALU result & ~1
//   illegal           : one-cycle pulse in DECODE on an undecodable instruction
//   state[2:0]        : FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//   instret[31:0]     : retired-instruction count
//
// Build option
//   MULTICYCLE_CTRL_PERF_EN : when defined, instret counts retired instructions
//                             (wrapping); when undefined it is constant 0.
// ----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  ALUCtrl,
    output logic        alu_a_pc,
    output logic        alu_b_imm,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_AUIPC = 4'b1000;
    localparam logic [3:0] ALU_LUI   = 4'b1001;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_SRL   = 4'b1100;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    // Decoded view of IR
    logic [3:0] dec_alu;
    logic       dec_apc, dec_bimm;
    logic [1:0] dec_wbsel, dec_pcsrc;
    logic       dec_ill, dec_load, dec_store, dec_branch;
    logic       br_on_zero;        // branch taken when Zero=1 (else when Zero=0)

    // Only opcode, funct3 and bit 30 steer control; the rest is datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_alu    = ALU_ADD;
        dec_apc    = 1'b0;
        dec_bimm   = 1'b0;
        dec_wbsel  = 2'b00;
        dec_pcsrc  = 2'b00;
        dec_ill    = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        br_on_zero = 1'b0;
        case (ir_q[6:0])
            OPC_OP:    dec_alu = alu_from_funct3(ir_q[14:12], ir_q[30]);
            OPC_OPIMM: begin
                // ADDI has no SUB form, so bit 30 only matters for shifts.
                dec_alu  = alu_from_funct3(ir_q[14:12], (ir_q[14:12] == 3'b101) & ir_q[30]);
                dec_bimm = 1'b1;
            end
            OPC_LOAD: begin
                dec_bimm = 1'b1;
                dec_load = 1'b1;
                dec_wbsel = 2'b01;
            end
            OPC_STORE: begin
                dec_bimm  = 1'b1;
                dec_store = 1'b1;
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                case (ir_q[14:12])
                    3'b000:  begin dec_alu = ALU_SUB;  br_on_zero = 1'b1; end
                    3'b001:  dec_alu = ALU_SUB;
                    3'b100:  dec_alu = ALU_SLT;
                    3'b101:  begin dec_alu = ALU_SLT;  br_on_zero = 1'b1; end
                    3'b110:  dec_alu = ALU_SLTU;
                    3'b111:  begin dec_alu = ALU_SLTU; br_on_zero = 1'b1; end
                    default: dec_ill = 1'b1;
                endcase
            end
            // LUI/AUIPC take the U-immediate on the B operand.
            OPC_LUI:   begin dec_alu = ALU_LUI;   dec_bimm = 1'b1; end
            OPC_AUIPC: begin dec_alu = ALU_AUIPC; dec_apc = 1'b1; dec_bimm = 1'b1; end
            OPC_JAL:   begin dec_wbsel = 2'b10; dec_pcsrc = 2'b01; end
            OPC_JALR:  begin dec_bimm = 1'b1; dec_wbsel = 2'b10; dec_pcsrc = 2'b10; end
            default:   dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        instr_ready = 1'b0;
        ALUCtrl     = ALU_ADD;
        alu_a_pc    = 1'b0;
        alu_b_imm   = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        illegal     = 1'b0;

        // ALU controls come straight from IR for the whole active phase,
        // which keeps them stable from EXEC through MEM/WB.
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            ALUCtrl   = dec_alu;
            alu_a_pc  = dec_apc;
            alu_b_imm = dec_bimm;
        end

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_ill) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = ((br_on_zero ? Zero : ~Zero)) ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end else if (dec_load || dec_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_re = dec_load;
                mem_we = dec_store;
                if (mem_ready) begin
                    if (dec_store) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = dec_wbsel;
                pc_we   = 1'b1;
                pc_src  = dec_pcsrc;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    // Every retire (WB, branch EXEC, store completion) is exactly the one
    // pc_we cycle of its instruction; illegal instructions never raise pc_we.
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
